// File: rtl/control_pipe.sv
// Decode-side control pipeline: carries the decoded control bundle through ID/EX, EX/MEM and
// MEM/WB, resolves PCSrcE in Execute, and counts retired instructions and bubbles.
module control_pipe #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             ALUSrcD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [REG_W-1:0] RdD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             ALUSrcE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [REG_W-1:0] RdE,
  output logic             PCSrcE,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [REG_W-1:0] RdM,
  output logic             ValidW,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [REG_W-1:0] RdW,
  output logic [CNT_W-1:0] InstRet,
  output logic [CNT_W-1:0] BubbleCnt
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             alu_src;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic [1:0]       result_src;
    logic [2:0]       alu_control;
    logic [REG_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
    logic [REG_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [REG_W-1:0] rd;
  } wb_t;

  ex_t              ex_d, ex_q;
  mem_t             mem_d, mem_q;
  wb_t              wb_d, wb_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic [CNT_W-1:0] bubble_d, bubble_q;

  // ID/EX: flush beats stall beats load; an invalid D slot always enters as a clean bubble.
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      if (ValidD) begin
        ex_d.valid       = 1'b1;
        ex_d.reg_write   = RegWriteD;
        ex_d.alu_src     = ALUSrcD;
        ex_d.mem_write   = MemWriteD;
        ex_d.branch      = BranchD;
        ex_d.jump        = JumpD;
        ex_d.result_src  = ResultSrcD;
        ex_d.alu_control = ALUControlD;
        ex_d.rd          = RdD;
      end else begin
        ex_d = '0;
      end
    end
  end

  // EX/MEM: a held E instruction has not advanced, so M receives a bubble behind it.
  always_comb begin
    mem_d = '0;
    if (!(StallE && !FlushE)) begin
      mem_d.valid      = ex_q.valid;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.result_src = ex_q.result_src;
      mem_d.rd         = ex_q.rd;
    end
  end

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = mem_q.valid;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.result_src = mem_q.result_src;
    wb_d.rd         = mem_q.rd;
  end

  always_comb begin
    instret_d = instret_q;
    bubble_d  = bubble_q;
    if (wb_q.valid) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      instret_q <= '0;
      bubble_q  <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      instret_q <= instret_d;
      bubble_q  <= bubble_d;
    end
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ALUSrcE     = ex_q.alu_src;
  assign MemWriteE   = ex_q.mem_write;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_control;
  assign RdE         = ex_q.rd;
  assign PCSrcE      = ex_q.valid & ((ex_q.branch & ZeroE) | ex_q.jump);

  assign ValidM      = mem_q.valid;
  assign RegWriteM   = mem_q.reg_write;
  assign MemWriteM   = mem_q.mem_write;
  assign ResultSrcM  = mem_q.result_src;
  assign RdM         = mem_q.rd;

  assign ValidW      = wb_q.valid;
  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign RdW         = wb_q.rd;

  assign InstRet     = instret_q;
  assign BubbleCnt   = bubble_q;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed vector table, a counter-wrap sequence on a
// 4-bit-counter instance, and randomized traffic against a stage-level reference model.
module tb_control_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ValidD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] RdD;
  logic       StallE, FlushE, ZeroE;

  logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, PCSrcE;
  logic [1:0]  ResultSrcE, ResultSrcM, ResultSrcW;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE, RdM, RdW;
  logic        ValidM, RegWriteM, MemWriteM, ValidW, RegWriteW;
  logic [31:0] InstRet, BubbleCnt;

  logic        v4E, rw4E, as4E, mw4E, br4E, j4E, pc4, v4M, rw4M, mw4M, v4W, rw4W;
  logic [1:0]  rs4E, rs4M, rs4W;
  logic [2:0]  alu4E;
  logic [4:0]  rd4E, rd4M, rd4W;
  logic [3:0]  ir4, bc4;

  control_pipe dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RdD(RdD), .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RdE(RdE), .PCSrcE(PCSrcE), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .ValidW(ValidW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .InstRet(InstRet),
    .BubbleCnt(BubbleCnt)
  );

  control_pipe #(.CNT_W(4), .REG_W(5)) dut4 (
    .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RdD(RdD), .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
    .ValidE(v4E), .RegWriteE(rw4E), .ALUSrcE(as4E), .MemWriteE(mw4E), .BranchE(br4E),
    .JumpE(j4E), .ResultSrcE(rs4E), .ALUControlE(alu4E), .RdE(rd4E), .PCSrcE(pc4),
    .ValidM(v4M), .RegWriteM(rw4M), .MemWriteM(mw4M), .ResultSrcM(rs4M), .RdM(rd4M),
    .ValidW(v4W), .RegWriteW(rw4W), .ResultSrcW(rs4W), .RdW(rd4W), .InstRet(ir4),
    .BubbleCnt(bc4)
  );

  typedef struct packed {
    logic vE, rwE, asE, mwE, brE, jE;
    logic [1:0] rsE;
    logic [2:0] aluE;
    logic [4:0] rdE;
    logic pc, vM, rwM, mwM;
    logic [1:0] rsM;
    logic [4:0] rdM;
    logic vW, rwW;
    logic [1:0] rsW;
    logic [4:0] rdW;
    logic [31:0] ir, bc;
  } obs_t;

  // Reference model: one instruction record per stage plus plain counters.
  typedef struct packed {
    logic v, rw, as, mw, br, j;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [4:0] rd;
  } ins_t;

  ins_t        m_e, m_m, m_w;
  int unsigned m_ir, m_bc;

  int checks = 0;
  int failures = 0;

  function automatic obs_t dut_obs();
    obs_t o;
    o = {ValidE, RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE, RdE,
         PCSrcE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM, ValidW, RegWriteW, ResultSrcW,
         RdW, InstRet, BubbleCnt};
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    o.vE = m_e.v; o.rwE = m_e.rw; o.asE = m_e.as; o.mwE = m_e.mw; o.brE = m_e.br;
    o.jE = m_e.j; o.rsE = m_e.rs; o.aluE = m_e.alu; o.rdE = m_e.rd;
    o.pc = m_e.v && ((m_e.br && ZeroE) || m_e.j);
    o.vM = m_m.v; o.rwM = m_m.rw; o.mwM = m_m.mw; o.rsM = m_m.rs; o.rdM = m_m.rd;
    o.vW = m_w.v; o.rwW = m_w.rw; o.rsW = m_w.rs; o.rdW = m_w.rd;
    o.ir = m_ir; o.bc = m_bc;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp, input obs_t got);
    checks++;
    if (exp !== got) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] exp, input logic [31:0] got);
    checks++;
    if (exp !== got) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Advance one clock; model applies the pipeline rules to the inputs held across the edge.
  task automatic tick();
    ins_t d, ne, nm, nw;
    int unsigned nir, nbc;
    d = '{v: ValidD, rw: RegWriteD, as: ALUSrcD, mw: MemWriteD, br: BranchD, j: JumpD,
          rs: ResultSrcD, alu: ALUControlD, rd: RdD};
    if (!ValidD) d = '0;
    nir = m_ir + (m_w.v ? 1 : 0);
    nbc = m_bc + (m_w.v ? 0 : 1);
    nw = m_m;
    if (StallE && !FlushE) nm = '0;
    else nm = '{v: m_e.v, rw: m_e.rw, as: 1'b0, mw: m_e.mw, br: 1'b0, j: 1'b0,
                rs: m_e.rs, alu: 3'd0, rd: m_e.rd};
    if (FlushE) ne = '0;
    else if (StallE) ne = m_e;
    else ne = d;
    if (rst) begin
      ne = '0; nm = '0; nw = '0; nir = 0; nbc = 0;
    end
    @(posedge clk);
    #1;
    m_e = ne; m_m = nm; m_w = nw; m_ir = nir; m_bc = nbc;
  endtask

  task automatic drive(input bit r, input bit vd, input bit rwd, input bit mwd, input bit brd,
                       input bit jd, input logic [4:0] rd, input bit st, input bit fl,
                       input bit z);
    rst = r; ValidD = vd; RegWriteD = rwd; MemWriteD = mwd; BranchD = brd; JumpD = jd;
    RdD = rd; StallE = st; FlushE = fl; ZeroE = z;
    ALUSrcD = 1'b0; ResultSrcD = 2'd0; ALUControlD = 3'd0;
  endtask

  typedef struct {
    bit r, vd, rwd, mwd, brd, jd;
    logic [4:0] rd;
    bit st, fl, z;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(
      input bit r, input bit vd, input bit rwd, input bit mwd, input bit brd, input bit jd,
      input int rd, input bit st, input bit fl, input bit z,
      input bit vE, input bit rwE, input bit mwE, input bit brE, input bit jE, input int rdE,
      input bit pc, input bit vM, input bit rwM, input bit mwM, input int rdM,
      input bit vW, input bit rwW, input int rdW, input int ir, input int bc);
    vec_t v;
    v.r = r; v.vd = vd; v.rwd = rwd; v.mwd = mwd; v.brd = brd; v.jd = jd; v.rd = 5'(rd);
    v.st = st; v.fl = fl; v.z = z;
    v.exp = '0;
    v.exp.vE = vE; v.exp.rwE = rwE; v.exp.mwE = mwE; v.exp.brE = brE; v.exp.jE = jE;
    v.exp.rdE = 5'(rdE); v.exp.pc = pc;
    v.exp.vM = vM; v.exp.rwM = rwM; v.exp.mwM = mwM; v.exp.rdM = 5'(rdM);
    v.exp.vW = vW; v.exp.rwW = rwW; v.exp.rdW = 5'(rdW);
    v.exp.ir = 32'(ir); v.exp.bc = 32'(bc);
    vecs.push_back(v);
  endtask

  initial begin
    m_e = '0; m_m = '0; m_w = '0; m_ir = 0; m_bc = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //      r vd rw mw br j rd st fl z | vE rw mw br j rd pc | vM rw mw rd | vW rw rd | ir bc
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0);
    add_vec(0, 1, 1, 0, 0, 0, 7, 0, 0, 0,  1, 1, 0, 0, 0, 7, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 7,  0, 0, 0,  0, 2);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 7,  0, 3);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1, 3);
    // branch taken, then held by stall with Zero dropped
    add_vec(0, 1, 0, 0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0,  1, 4);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  1, 5);
    add_vec(0, 1, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0,  0, 0, 0,  1, 6);
    // JumpD with ValidD=0 must not reach E
    add_vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0,  1, 7);
    // store held for two stall cycles
    add_vec(0, 1, 0, 1, 0, 0, 3, 0, 0, 0,  1, 0, 1, 0, 0, 3, 0,  0, 0, 0, 0,  1, 0, 0,  2, 7);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 3, 0,  0, 0, 0, 0,  0, 0, 0,  3, 7);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0, 3, 0,  0, 0, 0, 0,  0, 0, 0,  3, 8);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 3,  0, 0, 0,  3, 9);
    // flush + stall with a valid jump in D
    add_vec(0, 1, 0, 0, 0, 1, 9, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 3,  3, 10);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  4, 10);
    // three in flight, then reset
    add_vec(0, 1, 1, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0,  4, 11);
    add_vec(0, 1, 1, 0, 0, 0, 2, 0, 0, 0,  1, 1, 0, 0, 0, 2, 0,  1, 1, 0, 1,  0, 0, 0,  4, 12);
    add_vec(0, 1, 1, 0, 0, 0, 3, 0, 0, 0,  1, 1, 0, 0, 0, 3, 0,  1, 1, 0, 2,  1, 1, 1,  4, 13);
    add_vec(1, 1, 1, 0, 0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 1);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 2);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].vd, vecs[i].rwd, vecs[i].mwd, vecs[i].brd, vecs[i].jd,
            vecs[i].rd, vecs[i].st, vecs[i].fl, vecs[i].z);
      tick();
      check_obs($sformatf("vec%0d", i), vecs[i].exp, dut_obs());
    end

    // 16 back-to-back instructions on the 4-bit counter instance
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 1, 0, 0, 0, i[4:0], 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_val("wrap_ir4_before_last", 32'd15, {28'd0, ir4});
    tick();
    check_val("wrap_ir4", 32'd0, {28'd0, ir4});
    check_val("wrap_bc4", 32'd3, {28'd0, bc4});
    check_val("wrap_ir32", 32'd16, InstRet);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      ValidD      = ($urandom_range(0, 3) != 0);
      RegWriteD   = 1'($urandom);
      ALUSrcD     = 1'($urandom);
      MemWriteD   = 1'($urandom);
      BranchD     = 1'($urandom);
      JumpD       = ($urandom_range(0, 3) == 0);
      ResultSrcD  = 2'($urandom);
      ALUControlD = 3'($urandom);
      RdD         = 5'($urandom);
      StallE      = ($urandom_range(0, 3) == 0);
      FlushE      = ($urandom_range(0, 7) == 0);
      ZeroE       = 1'($urandom);
      tick();
      check_obs($sformatf("rand%0d", i), model_obs(), dut_obs());
      check_val($sformatf("rand%0d_cnt4", i), {24'd0, m_ir[3:0], m_bc[3:0]},
                {24'd0, ir4, bc4});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
